// File: rtl/product_accumulator.sv
// Sums groups of up to COUNT unsigned products from the multiplier and presents
// each group's sum and product count on a valid/ready output.
module product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned ACC_W  = 10,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  localparam logic [CNT_W-1:0] CountMax = CNT_W'(COUNT);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  count_q, count_d;
  // Keeps in_ready low until the first clock edge after reset release.
  logic              live_q;

  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_inc;

  assign acc_sum = acc_q + {{(ACC_W - PROD_W){1'b0}}, in_prod};
  assign cnt_inc = cnt_q + CNT_W'(1);

  assign in_ready  = live_q && (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign out_sum   = sum_q;
  assign out_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    count_d = count_q;
    // clear wins over a same-cycle accept or output handshake.
    if (clear) begin
      state_d = StAccum;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (in_valid && in_ready) begin
            if ((cnt_inc == CountMax) || in_last) begin
              sum_d   = acc_sum;
              count_d = cnt_inc;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StHold;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_inc;
            end
          end
        end
        StHold: begin
          if (out_ready) state_d = StAccum;
        end
        default: state_d = StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and random checks of product_accumulator against a queue-based model.
module tb_product_accumulator;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_prod;
  logic       in_last;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic [2:0] out_count;

  int checks = 0;
  int errors = 0;

  // Reference model: products of the open group, plus the pending result.
  int q[$];
  bit m_started;
  bit m_hold;
  int m_sum;
  int m_cnt;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_started = 1'b0;
    m_hold    = 1'b0;
    m_sum     = 0;
    m_cnt     = 0;
  endtask

  task automatic model_step(input bit v, input int p, input bit l, input bit c, input bit r);
    int s;
    if (c) begin
      q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else if (v && m_started) begin
      q.push_back(p);
      if (q.size() == COUNT || l) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_sum  = s;
        m_cnt  = q.size();
        q.delete();
        m_hold = 1'b1;
      end
    end
    m_started = 1'b1;
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next fall.
  task automatic cyc(input bit v, input int p, input bit l, input bit c, input bit r);
    in_valid  = v;
    in_prod   = p[7:0];
    in_last   = l;
    clear     = c;
    out_ready = r;
    @(posedge clk);
    model_step(v, p, l, c, r);
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_started && !m_hold});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
    if (m_hold) begin
      chk("out_sum", {22'b0, out_sum}, m_sum);
      chk("out_count", {29'b0, out_count}, m_cnt);
    end
  endtask

  task automatic idle(input bit r);
    cyc(1'b0, 0, 1'b0, 1'b0, r);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_prod = '0; in_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_sum", {22'b0, out_sum}, 0);
    chk("rst_out_count", {29'b0, out_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Full group of 15*15 products.
    for (int i = 0; i < 4; i++) cyc(1'b1, 225, 1'b0, 1'b0, 1'b1);
    chk("full_sum", {22'b0, out_sum}, 900);
    chk("full_count", {29'b0, out_count}, 4);
    chk("full_bubble", {31'b0, in_ready}, 0);
    cyc(1'b1, 225, 1'b0, 1'b0, 1'b1);
    chk("full_ready_back", {31'b0, in_ready}, 1);
    idle(1'b1);

    // Early close, then a full group.
    cyc(1'b1, 42, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 15, 1'b1, 1'b0, 1'b1);
    chk("early_sum", {22'b0, out_sum}, 57);
    chk("early_count", {29'b0, out_count}, 2);
    idle(1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b1);
    chk("seq_sum", {22'b0, out_sum}, 10);
    chk("seq_count", {29'b0, out_count}, 4);
    idle(1'b1);

    // Backpressure for five cycles.
    cyc(1'b1, 40, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 60, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 7, 1'b0, 1'b0, 1'b0);
      chk("bp_sum", {22'b0, out_sum}, 100);
      chk("bp_valid", {31'b0, out_valid}, 1);
    end
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("bp_taken", {31'b0, out_valid}, 0);

    // Input gaps mid-group.
    cyc(1'b1, 8, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b1);
    cyc(1'b1, 9, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    cyc(1'b1, 10, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 11, 1'b0, 1'b0, 1'b1);
    chk("gap_sum", {22'b0, out_sum}, 38);
    chk("gap_count", {29'b0, out_count}, 4);
    idle(1'b1);

    // clear mid-group, then clear while holding a result.
    cyc(1'b1, 50, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 60, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 99, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    chk("clr_sum", {22'b0, out_sum}, 4);
    chk("clr_count", {29'b0, out_count}, 4);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk("clr_hold", {31'b0, out_valid}, 0);

    // Asynchronous reset between edges with 120 accumulated.
    cyc(1'b1, 60, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 60, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_in_ready", {31'b0, in_ready}, 0);
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_out_sum", {22'b0, out_sum}, 0);
    chk("arst_out_count", {29'b0, out_count}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    idle(1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2, 1'b0, 1'b0, 1'b1);
    chk("arst_sum", {22'b0, out_sum}, 8);
    chk("arst_count", {29'b0, out_count}, 4);
    idle(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7,
          int'($urandom_range(0, 15) * $urandom_range(0, 15)),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 31) == 0,
          $urandom_range(0, 4) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
